// File: rtl/ghost_pkg.sv
// ghost_pkg: shared types and helpers for the ghost mode sequencer.
//   mode_e   : one-hot ghost mode as seen by the target/path stage
//   dir_e    : ghost movement directions
//   gstate_e : sequencer top-level state
//   pend_t   : latched event pulses awaiting the next commit
//   phase_len: reload value for a schedule phase index 0..7
package ghost_pkg;

  typedef enum logic [3:0] {
    CHASE      = 4'b1000,
    SCATTER    = 4'b0100,
    FRIGHTENED = 4'b0010,
    EATEN      = 4'b0001
  } mode_e;

  typedef enum logic [1:0] {LEFT, RIGHT, UP, DOWN} dir_e;

  typedef enum logic [1:0] {ST_SCHED, ST_FRIGHT, ST_EATEN} gstate_e;

  typedef struct packed {
    logic energizer;
    logic ghost_eaten;
    logic ghost_home;
  } pend_t;

  // Phase 7 is the endless chase; its counter value is never consulted.
  localparam logic [2:0] LAST_PHASE = 3'd7;

  // Odd phases are chase; even phases 0/2 use the long scatter,
  // 4/6 the short one.
  function automatic logic [15:0] phase_len(input logic [2:0]  p,
                                            input logic [15:0] scat_a,
                                            input logic [15:0] scat_b,
                                            input logic [15:0] chase_len);
    if (p[0])      return chase_len;
    else if (p[2]) return scat_b;
    else           return scat_a;
  endfunction

endpackage

// File: rtl/ghost_mode_ctrl_if.sv
// ghost_mode_ctrl_if: event inputs and ghost-facing outputs of one ghost
// sequencer.
//   tick, energizer, ghost_eaten, ghost_home : one-clk pulses into the block
//   update : step strobe, mode : one-hot mode, rotate : reverse request
//   flash  : present only when GHOST_FLASH_EN is defined
// master = event source / ghost consumer, slave = ghost_mode_ctrl.
interface ghost_mode_ctrl_if;
  logic       tick;
  logic       energizer;
  logic       ghost_eaten;
  logic       ghost_home;
  logic       update;
  logic [3:0] mode;
  logic       rotate;
`ifdef GHOST_FLASH_EN
  logic       flash;

  modport master (output tick, energizer, ghost_eaten, ghost_home,
                  input  update, mode, rotate, flash);
  modport slave  (input  tick, energizer, ghost_eaten, ghost_home,
                  output update, mode, rotate, flash);
`else
  modport master (output tick, energizer, ghost_eaten, ghost_home,
                  input  update, mode, rotate);
  modport slave  (input  tick, energizer, ghost_eaten, ghost_home,
                  output update, mode, rotate);
`endif
endinterface

// File: rtl/ghost_mode_ctrl_update_strobe_gen.sv
// update_strobe_gen: divides frame ticks down to ghost updates and stretches
// each update to UPD_HIGH clocks.
//   clk, reset : clock, synchronous active-high reset
//   tick       : one-clk frame pulse
//   update     : high for exactly UPD_HIGH clks, starting the clk after the
//                TICK_DIV-th tick
//   commit     : one-clk pulse in the first clk update is low again
module update_strobe_gen #(
  parameter int TICK_DIV = 4,
  parameter int UPD_HIGH = 4
)(
  input  logic clk,
  input  logic reset,
  input  logic tick,
  output logic update,
  output logic commit
);

  logic [15:0] tcnt;
  logic [15:0] hcnt;
  logic        fire;

  assign fire = tick && (tcnt == 16'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt   <= '0;
      hcnt   <= '0;
      update <= 1'b0;
      commit <= 1'b0;
    end else begin
      commit <= 1'b0;
      // ticks keep counting while update is high
      if (tick) tcnt <= fire ? '0 : tcnt + 16'd1;
      // a divide-out landing inside a live window does not retrigger it,
      // so every window ends in exactly one commit
      if (fire && !update) begin
        update <= 1'b1;
        hcnt   <= 16'(UPD_HIGH);
      end else if (update) begin
        if (hcnt <= 16'd1) begin
          update <= 1'b0;
          commit <= 1'b1;
        end else begin
          hcnt <= hcnt - 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ghost_mode_ctrl.sv
// ghost_mode_ctrl: per-ghost mode sequencer feeding the target/path stage.
// Runs the scatter/chase schedule, the frightened timer after an energizer
// and the eaten-until-home state. All visible outputs change only on the
// commit clk (update falling), so they are stable over every high window.
//   clk, reset : clock, synchronous active-high reset
//   bus (slave): tick/energizer/ghost_eaten/ghost_home in;
//                update/mode/rotate (and flash) out
// Optional: define GHOST_FLASH_EN to add the flash output and FLASH_LEN.
module ghost_mode_ctrl
  import ghost_pkg::*;
#(
  parameter int TICK_DIV   = 4,
  parameter int UPD_HIGH   = 4,
  parameter int SCAT_A     = 56,
  parameter int SCAT_B     = 40,
  parameter int CHASE_LEN  = 160,
  parameter int FRIGHT_LEN = 48
`ifdef GHOST_FLASH_EN
  , parameter int FLASH_LEN = 16
`endif
)(
  input  logic              clk,
  input  logic              reset,
  ghost_mode_ctrl_if.slave  bus
);

  logic        update;
  logic        commit;

  gstate_e     st, st_n;
  logic [2:0]  phase, phase_n;
  logic [15:0] pcnt, pcnt_n;
  logic [15:0] fcnt, fcnt_n;
  logic        rot, rot_n;
  pend_t       pend;
  logic        ev_ener, ev_eaten, ev_home;

  update_strobe_gen #(
    .TICK_DIV (TICK_DIV),
    .UPD_HIGH (UPD_HIGH)
  ) u_strobe (
    .clk    (clk),
    .reset  (reset),
    .tick   (bus.tick),
    .update (update),
    .commit (commit)
  );

  assign bus.update = update;

  // Pulses latch until the next commit; a pulse landing on the commit clk
  // itself is honoured there rather than carried one window further.
  always_ff @(posedge clk) begin
    if (reset || commit) pend <= '0;
    else pend <= pend | pend_t'{bus.energizer, bus.ghost_eaten, bus.ghost_home};
  end

  assign ev_ener  = pend.energizer   | bus.energizer;
  assign ev_eaten = pend.ghost_eaten | bus.ghost_eaten;
  assign ev_home  = pend.ghost_home  | bus.ghost_home;

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= ST_SCHED;
      phase <= '0;
      pcnt  <= 16'(SCAT_A);
      fcnt  <= '0;
      rot   <= 1'b0;
    end else if (commit) begin
      st    <= st_n;
      phase <= phase_n;
      pcnt  <= pcnt_n;
      fcnt  <= fcnt_n;
      rot   <= rot_n;
    end
  end

  // next state: one transition per commit, highest priority first.
  // The schedule counter only moves in SCHED, so it resumes after
  // FRIGHT/EATEN exactly where it stopped. Unused pending flags simply
  // fall through and are dropped by the commit clear.
  always_comb begin
    st_n    = st;
    phase_n = phase;
    pcnt_n  = pcnt;
    fcnt_n  = fcnt;
    rot_n   = 1'b0;
    if (ev_home && st == ST_EATEN) begin
      st_n = ST_SCHED;
    end else if (ev_eaten && st == ST_FRIGHT) begin
      st_n = ST_EATEN;
    end else if (ev_ener && st != ST_EATEN) begin
      st_n   = ST_FRIGHT;
      fcnt_n = 16'(FRIGHT_LEN);
      rot_n  = (st == ST_SCHED);   // a reload inside FRIGHT does not reverse
    end else if (st == ST_FRIGHT) begin
      if (fcnt <= 16'd1) st_n = ST_SCHED;
      else               fcnt_n = fcnt - 16'd1;
    end else if (st == ST_SCHED && phase != LAST_PHASE) begin
      if (pcnt <= 16'd1) begin
        phase_n = phase + 3'd1;
        pcnt_n  = phase_len(phase + 3'd1, 16'(SCAT_A), 16'(SCAT_B),
                            16'(CHASE_LEN));
        rot_n   = 1'b1;
      end else begin
        pcnt_n = pcnt - 16'd1;
      end
    end
  end

  // outputs: all derived from commit-only registers
  always_comb begin
    bus.mode = SCATTER;
    unique case (st)
      ST_SCHED:  bus.mode = phase[0] ? CHASE : SCATTER;
      ST_FRIGHT: bus.mode = FRIGHTENED;
      ST_EATEN:  bus.mode = EATEN;
      default:   bus.mode = SCATTER;
    endcase
    bus.rotate = rot;
`ifdef GHOST_FLASH_EN
    // a reload puts fcnt back above FLASH_LEN, which clears flash
    bus.flash = (st == ST_FRIGHT) && (fcnt <= 16'(FLASH_LEN));
`endif
  end

endmodule
